// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package riscv_mem_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive BUSY cycles and flags expiry when the memory never acks.
module mem_watchdog
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic ack,
  output logic expire
);

  localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // cnt_q holds the number of BUSY cycles already elapsed, so expiry fires on the TIMEOUT-th one
  always_comb begin
    expire = busy && !ack && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (!busy || ack || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory,
// one transaction at a time, with anti-starvation for fetch and a busy timeout.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int SW = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic              busy;
  logic              expire;

  assign busy = (state_q != ST_IDLE);

  mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .ack   (mem_ack),
    .expire(expire)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Grants are suppressed during reset so no pulse escapes a cycle that will not be honoured
        if (!reset) begin
          if (if_req && (!d_req || starve_q == STARVE_MAX)) begin
            if_gnt   = 1'b1;
            starve_d = '0;
            addr_d   = if_addr;
            we_d     = 1'b0;
            state_d  = ST_BUSY_IF;
          end else if (d_req) begin
            d_gnt   = 1'b1;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            state_d = ST_BUSY_D;
            if (if_req && starve_q != STARVE_MAX) begin
              starve_d = starve_q + SW'(1);
            end
          end
        end
      end
      ST_BUSY_IF: begin
        if (mem_ack) begin
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
          state_d    = ST_IDLE;
        end else if (expire) begin
          if_done_d = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_BUSY_D: begin
        if (mem_ack) begin
          d_done_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = ST_IDLE;
        end else if (expire) begin
          d_done_d = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

  assign mem_req   = busy;
  assign mem_we    = busy && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, scoreboard-based bench for mem_port_arbiter: arbitration, starvation,
// store path, spurious ack, dropped request, timeout and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  typedef struct {
    logic        is_if;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT     (255)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic ifr, input logic [31:0] ifa,
                               input logic dr, input logic dwe, input logic [31:0] da,
                               input logic [31:0] dwd, input logic ack, input logic [31:0] rd);
    reset     = rst;
    if_req    = ifr;
    if_addr   = ifa;
    d_req     = dr;
    d_we      = dwe;
    d_addr    = da;
    d_wdata   = dwd;
    mem_ack   = ack;
    mem_rdata = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic popDone(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_scoreboard: observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_if_done"}, 32'(if_done), 32'(e.is_if));
      checkOutput({tag, "_d_done"}, 32'(d_done), 32'(!e.is_if));
      checkOutput({tag, "_rdata"}, e.is_if ? if_rdata : d_rdata, e.rdata);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global time limit expired");
  end

  initial begin
    int busy_cycles;
    int k;

    // Reset with both requesters already asserting
    applyStimulus(1, 1, 32'h20, 1, 0, 32'h40, 32'h0, 0, 32'h0);
    tick();
    tick();
    checkOutput("rst_if_gnt", 32'(if_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    checkOutput("rst_dones", 32'({if_done, d_done}), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);

    // Starvation: four data grants, fetch on the fifth, data again afterwards
    for (int a = 0; a < 6; a++) begin
      logic exp_if;
      exp_if = (a == 4);
      applyStimulus(0, 1, 32'h20, 1, 0, 32'h40, 32'h0, 0, 32'h0);
      checkOutput($sformatf("arb%0d_if_gnt", a), 32'(if_gnt), 32'(exp_if));
      checkOutput($sformatf("arb%0d_d_gnt", a), 32'(d_gnt), 32'(!exp_if));
      exp_q.push_back('{exp_if, 32'h1000 + 32'(a)});
      tick();
      applyStimulus(0, 1, 32'h20, 1, 0, 32'h40, 32'h0, 1, 32'h1000 + 32'(a));
      checkOutput($sformatf("arb%0d_mem_req", a), 32'(mem_req), 32'd1);
      checkOutput($sformatf("arb%0d_mem_addr", a), mem_addr, exp_if ? 32'h20 : 32'h40);
      checkOutput($sformatf("arb%0d_busy_gnt", a), 32'(if_gnt | d_gnt), 32'd0);
      tick();
      popDone($sformatf("arb%0d", a));
    end

    // Single fetch read with ack one cycle after mem_req
    applyStimulus(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("fetch_if_gnt", 32'(if_gnt), 32'd1);
    checkOutput("fetch_d_gnt", 32'(d_gnt), 32'd0);
    exp_q.push_back('{1'b1, 32'h00500093});
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h00500093);
    checkOutput("fetch_mem_req", 32'(mem_req), 32'd1);
    checkOutput("fetch_mem_addr", mem_addr, 32'h10);
    checkOutput("fetch_mem_we", 32'(mem_we), 32'd0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    popDone("fetch");
    checkOutput("fetch_mem_req_after", 32'(mem_req), 32'd0);
    tick();
    checkOutput("fetch_done_once", 32'(if_done), 32'd0);
    checkOutput("fetch_rdata_held", if_rdata, 32'h00500093);

    // Store with ack in the third BUSY cycle; inputs change while busy
    applyStimulus(0, 0, 32'h0, 1, 1, 32'h8, 32'hDEADBEEF, 0, 32'h0);
    checkOutput("store_d_gnt", 32'(d_gnt), 32'd1);
    exp_q.push_back('{1'b0, 32'h1005});
    tick();
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(0, 0, 32'h0, 0, 1, 32'h44, 32'h12345678, (c == 3), 32'hFFFFFFFF);
      checkOutput($sformatf("store_c%0d_mem_req", c), 32'(mem_req), 32'd1);
      checkOutput($sformatf("store_c%0d_mem_we", c), 32'(mem_we), 32'd1);
      checkOutput($sformatf("store_c%0d_mem_wdata", c), mem_wdata, 32'hDEADBEEF);
      checkOutput($sformatf("store_c%0d_mem_addr", c), mem_addr, 32'h8);
      checkOutput($sformatf("store_c%0d_d_done", c), 32'(d_done), 32'd0);
      tick();
    end
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    popDone("store");
    tick();
    checkOutput("store_done_once", 32'(d_done), 32'd0);
    checkOutput("store_rdata_kept", d_rdata, 32'h1005);

    // Spurious ack while idle with no requests
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'hBAD0BAD0);
    checkOutput("spur_gnt", 32'(if_gnt | d_gnt), 32'd0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("spur_dones", 32'({if_done, d_done}), 32'd0);
    checkOutput("spur_mem_req", 32'(mem_req), 32'd0);
    checkOutput("spur_if_rdata", if_rdata, 32'h00500093);
    checkOutput("spur_d_rdata", d_rdata, 32'h1005);

    // Still idle: a fetch is granted at once; a data request dropped while busy gets nothing
    applyStimulus(0, 1, 32'h30, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("spur_still_idle_if_gnt", 32'(if_gnt), 32'd1);
    exp_q.push_back('{1'b1, 32'h11111111});
    tick();
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h50, 32'h0, 0, 32'h0);
    checkOutput("drop_busy_d_gnt", 32'(d_gnt), 32'd0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h11111111);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    popDone("drop_fetch");
    checkOutput("drop_no_gnt", 32'(d_gnt | if_gnt), 32'd0);
    tick();
    checkOutput("drop_no_done", 32'({if_done, d_done}), 32'd0);
    checkOutput("drop_mem_req", 32'(mem_req), 32'd0);

    // Timeout: fetch never acked
    applyStimulus(0, 1, 32'h80, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("to_if_gnt", 32'(if_gnt), 32'd1);
    exp_q.push_back('{1'b1, 32'h11111111});
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    busy_cycles = 0;
    k = 0;
    while (!if_done && k < 400) begin
      if (mem_req) busy_cycles++;
      if (k == 100) checkOutput("to_err_mid", 32'(err), 32'd0);
      tick();
      k++;
    end
    checkOutput("to_busy_cycles", 32'(busy_cycles), 32'd255);
    popDone("timeout");
    checkOutput("to_err_set", 32'(err), 32'd1);
    checkOutput("to_mem_req_low", 32'(mem_req), 32'd0);
    tick();
    checkOutput("to_done_once", 32'(if_done), 32'd0);

    // err is sticky across a later successful transaction
    applyStimulus(0, 1, 32'h84, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("sticky_if_gnt", 32'(if_gnt), 32'd1);
    exp_q.push_back('{1'b1, 32'h22222222});
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h22222222);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    popDone("sticky");
    tick();
    checkOutput("sticky_err", 32'(err), 32'd1);

    // Reset one cycle after d_gnt, colliding with mem_ack
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h40, 32'h0, 0, 32'h0);
    checkOutput("mrst_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'h77777777);
    checkOutput("mrst_busy_mem_req", 32'(mem_req), 32'd1);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    checkOutput("mrst_dones", 32'({if_done, d_done}), 32'd0);
    checkOutput("mrst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("mrst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("mrst_mem_addr", mem_addr, 32'h0);
    checkOutput("mrst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("mrst_d_rdata", d_rdata, 32'h0);
    checkOutput("mrst_if_rdata", if_rdata, 32'h0);
    checkOutput("mrst_err", 32'(err), 32'd0);
    tick();
    checkOutput("mrst_no_late_done", 32'({if_done, d_done}), 32'd0);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
